bcd_result_converter: RTL and testbench

//  Downstream stage of the 4-bit carry-lookahead adder in the calculator datapath.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/bcd_result_converter_if.sv | 37 +++
 rtl/bcd_digit_adjust.sv | 21 ++
 rtl/bcd_result_converter.sv | 166 ++++++++++++++++
 tb/tb_bcd_result_converter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Calculator datapath shared definitions: BCD conversion FSM states, digit
// adjust constants and a small elaboration-time helper. Shared with the
// display stage.
package calc_pkg;

    // Conversion FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } calc_state_e;

    // Width of one packed BCD digit
    localparam int BCD_DIGIT_W = 4;

    // Double-dabble digit adjust: digits at or above the threshold get +3
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // 10**n as a constant function, used to check the digit count is enough
    function automatic longint pow10(input int n);
        longint acc;
        acc = 64'sd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'sd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_result_converter_if.sv
// Handshake bundle between the adder (upstream), the BCD converter and the
// display stage (downstream). The converter sits on the slave modport; the
// surrounding stages (or a bench) use the master modport.
interface bcd_result_converter_if
    import calc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
    logic                          out_neg;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_neg
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_neg
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// One double-dabble digit correction: a BCD digit of 5 or more gets +3
// (plain 4-bit add, any carry is dropped) so the following left shift
// carries correctly into the next decimal digit.
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // Conditional +3 correction of a single digit
    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + BCD_ADJ_ADD;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bcd_result_converter.sv
// Binary-to-packed-BCD converter behind the carry-lookahead adder.
// Sequential double-dabble, one shift per clock, valid/ready on both sides.
// Optional build macro: CALC_SIGNED_EN -- treat in_data as two's complement,
// convert the magnitude and report the sign on out_neg. Without it in_data is
// unsigned and out_neg is constant 0.
module bcd_result_converter
    import calc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
)(
    input logic               clk,
    input logic               rst,
    bcd_result_converter_if.slave bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam longint MAX_BIN = (64'sd1 <<< WIDTH) - 64'sd1;

    // Refuse to build a converter whose digits cannot hold the largest input
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digit_check
        $error("bcd_result_converter: DIGITS too small for WIDTH");
    end

    calc_state_e      state_r;
    calc_state_e      next_state_s;
    logic [WIDTH-1:0] bin_r;
    logic [BCD_W-1:0] bcd_r;
    logic [CNT_W-1:0] count_r;
    logic             neg_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [BCD_W-1:0] out_bcd_r;
    logic             out_neg_r;

    logic [BCD_W-1:0] bcd_adj_s;
    logic [BCD_W-1:0] shift_bcd_s;
    logic [WIDTH-1:0] shift_bin_s;
    logic [WIDTH-1:0] load_mag_s;
    logic             load_neg_s;
    logic             accept_s;
    logic             last_shift_s;

    // Digit correction applied to every BCD digit before each shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shift_bcd_s  = {bcd_adj_s[BCD_W-2:0], bin_r[WIDTH-1]};
    assign shift_bin_s  = {bin_r[WIDTH-2:0], 1'b0};
    assign accept_s     = (state_r == IDLE) && bus.in_valid && in_ready_r;
    assign last_shift_s = (state_r == SHIFT) && (count_r == LAST_CNT);

`ifdef CALC_SIGNED_EN
    // Magnitude in WIDTH unsigned bits, so the most negative value still fits
    always_comb begin
        load_neg_s = bus.in_data[WIDTH-1];
        if (bus.in_data[WIDTH-1]) begin
            load_mag_s = ~bus.in_data + WIDTH'(1);
        end else begin
            load_mag_s = bus.in_data;
        end
    end
`else
    // Unsigned operand: load as is, never negative
    always_comb begin
        load_neg_s = 1'b0;
        load_mag_s = bus.in_data;
    end
`endif

    // Next-state decode for the IDLE -> SHIFT -> DONE -> IDLE sequence
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (count_r == LAST_CNT) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Working registers: load on accept, one double-dabble step per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r   <= '0;
            bcd_r   <= '0;
            count_r <= '0;
            neg_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        bin_r   <= load_mag_s;
                        bcd_r   <= '0;
                        count_r <= '0;
                        neg_r   <= load_neg_s;
                    end
                end
                SHIFT: begin
                    bcd_r   <= shift_bcd_s;
                    bin_r   <= shift_bin_s;
                    count_r <= count_r + CNT_W'(1);
                end
                default: begin
                    bin_r   <= bin_r;
                end
            endcase
        end
    end

    // Registered handshake outputs; the result is captured only on entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_bcd_r   <= '0;
            out_neg_r   <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
            if (last_shift_s) begin
                out_bcd_r <= shift_bcd_s;
                out_neg_r <= neg_r && (shift_bcd_s != '0);
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_bcd   = out_bcd_r;
    assign bus.out_neg   = out_neg_r;

endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed bench for bcd_result_converter: a 4-bit/2-digit instance driven from
// a vector table plus hand-written back-pressure and reset sequences, and an
// 8-bit/3-digit instance swept over every input against a decimal model.
// Honours CALC_SIGNED_EN the same way the design does.
module tb_bcd_result_converter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_result_converter_if #(.WIDTH(4), .DIGITS(2)) bus4();
    bcd_result_converter_if #(.WIDTH(8), .DIGITS(3)) bus8();

    bcd_result_converter #(.WIDTH(4), .DIGITS(2)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    bcd_result_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] data;
        logic [7:0] bcd;
        logic       neg;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One conversion on the 4-bit instance; optional hold in DONE with in_valid pulses
    task automatic run4(input logic [3:0] d, input logic [7:0] eb, input logic en,
                        input int hold, input bit pulse);
        int n;
        int lat;
        @(negedge clk);
        bus4.in_valid = 1'b1;
        bus4.in_data  = d;
        n = 0;
        while (!bus4.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            chk("in_ready_shift", 32'(bus4.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency4", 32'(lat), 32'd4);
        chk("out_bcd", 32'(bus4.out_bcd), 32'(eb));
        chk("out_neg", 32'(bus4.out_neg), 32'(en));
        chk("in_ready_done", 32'(bus4.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                bus4.in_valid = ((i % 2) == 0);
                bus4.in_data  = ~d;
            end
            @(negedge clk);
            chk("bp_valid", 32'(bus4.out_valid), 32'd1);
            chk("bp_bcd", 32'(bus4.out_bcd), 32'(eb));
            chk("bp_in_ready", 32'(bus4.in_ready), 32'd0);
        end
        bus4.in_valid  = 1'b0;
        bus4.in_data   = d;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        chk("valid_drop", 32'(bus4.out_valid), 32'd0);
        chk("ready_back", 32'(bus4.in_ready), 32'd1);
        chk("bcd_hold", 32'(bus4.out_bcd), 32'(eb));
    endtask

    // Decimal reference for the 8-bit instance: {neg, bcd[11:0]}
    function automatic logic [12:0] ref8(input logic [7:0] v);
        int  mag;
        logic neg;
`ifdef CALC_SIGNED_EN
        neg = v[7];
        mag = v[7] ? (256 - int'(v)) : int'(v);
`else
        neg = 1'b0;
        mag = int'(v);
`endif
        return {neg && (mag != 0), 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    // One conversion on the 8-bit instance, compared against the model
    task automatic run8(input logic [7:0] d);
        int n;
        int lat;
        logic [12:0] exp;
        exp = ref8(d);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        n = 0;
        while (!bus8.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (d == 8'd255 || d == 8'd0) begin
            chk("latency8", 32'(lat), 32'd8);
        end
        chk("sweep8", 32'({bus8.out_neg, bus8.out_bcd}), 32'(exp));
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
`ifdef CALC_SIGNED_EN
        vecs[0] = '{4'b1001, 8'h07, 1'b1};
        vecs[1] = '{4'b1000, 8'h08, 1'b1};
        vecs[2] = '{4'b0000, 8'h00, 1'b0};
        vecs[3] = '{4'b0111, 8'h07, 1'b0};
        vecs[4] = '{4'b1111, 8'h01, 1'b1};
        vecs[5] = '{4'b0101, 8'h05, 1'b0};
        vecs[6] = '{4'b1100, 8'h04, 1'b1};
        vecs[7] = '{4'b0001, 8'h01, 1'b0};
`else
        vecs[0] = '{4'd15, 8'h15, 1'b0};
        vecs[1] = '{4'd0,  8'h00, 1'b0};
        vecs[2] = '{4'd9,  8'h09, 1'b0};
        vecs[3] = '{4'd12, 8'h12, 1'b0};
        vecs[4] = '{4'd7,  8'h07, 1'b0};
        vecs[5] = '{4'd10, 8'h10, 1'b0};
        vecs[6] = '{4'd1,  8'h01, 1'b0};
        vecs[7] = '{4'd5,  8'h05, 1'b0};
`endif
        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = 4'd0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_data = 8'd0; bus8.out_ready = 1'b0;
        #22;
        chk("rst_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_bcd", 32'(bus4.out_bcd), 32'd0);
        chk("rst_neg", 32'(bus4.out_neg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run4(vecs[i].data, vecs[i].bcd, vecs[i].neg, 0, 1'b0);
        end

        // Back-pressure with ignored input pulses
`ifdef CALC_SIGNED_EN
        run4(4'b0110, 8'h06, 1'b0, 10, 1'b1);
`else
        run4(4'd12, 8'h12, 1'b0, 10, 1'b1);
`endif

        // Reset after two shifts aborts the conversion
        @(negedge clk);
        bus4.in_valid = 1'b1;
        bus4.in_data  = 4'd3;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
        chk("mid_rst_bcd", 32'(bus4.out_bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus4.in_ready), 32'd1);
        chk("mid_rst_valid2", 32'(bus4.out_valid), 32'd0);
        run4(4'd7, 8'h07, 1'b0, 0, 1'b0);

        // Wide instance: full sweep, 255 first for the latency corner
        run8(8'd255);
        for (int v = 0; v < 256; v++) begin
            run8(8'(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
